aes_io_bridge: RTL
==================

AES_IO_BRIDGE -- requirements
Module: aes_io_bridge

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- PORT_W, 8: byte-lane width of both software ports.
- MSG_BYTES, 16: message length in lanes; message bus width MW = PORT_W*MSG_BYTES.
- KEY_BYTES, 16: key length in lanes; key bus width KW = PORT_W*KEY_BYTES.
- TIMEOUT_CYC, 1024: maximum handshake wait in cycles; 0 disables the timeout.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: the single clock.
- reset_n, in, 1: reset, synchronous and active-low.
- to_hw_sig, in, 2: software command/handshake code.
- to_hw_port, in, PORT_W: software data lane.
- to_sw_sig, out, 2: hardware status/handshake code.
- to_sw_port, out, PORT_W: hardware data lane.
- msg_en, out, MW: assembled encrypted message.
- key, out, KW: assembled key.
- msg_de, in, MW: decrypted result from the AES core.
- io_ready, out, 1: operands valid, start request to AES.
- aes_ready, in, 1: AES result valid.
- err, out, 1: sticky protocol-timeout flag.
REQ-003 One clock only; reset is synchronous and active-low; no asynchronous logic.

Function
REQ-004 Lane i (0-based) maps to bits [W-1-PORT_W*i -: PORT_W]; lane 0 is the MS lane of every bus.
REQ-005 Lane index: one counter idx, width clog2(max(MSG_BYTES,KEY_BYTES)); no per-lane states.
REQ-006 States: RESET, WAIT, RD, RD_ACK, AES_GO, AES_WAIT, SB, SB_ACK, ERR; a 1-bit target register selects MSG or KEY while in RD/RD_ACK.
REQ-007 RESET -> WAIT unconditionally; to_sw_sig=3.
REQ-008 WAIT, to_sw_sig=0.
- to_hw_sig=1 -> RD, target=MSG, idx=0.
- to_hw_sig=2 -> RD, target=KEY, idx=0.
- to_hw_sig=3 -> AES_GO.
- to_hw_sig=0 -> stay.
REQ-009 RD, to_sw_sig=1: every cycle, the selected lane idx of msg_en or key is loaded from to_hw_port; to_hw_sig=2 -> RD_ACK.
REQ-010 RD_ACK, to_sw_sig=0, no load; on to_hw_sig=1:
- idx = last lane of target (MSG_BYTES-1 or KEY_BYTES-1) -> WAIT;
- otherwise idx+1 and -> RD.
REQ-011 AES_GO: io_ready=1, to_sw_sig=0; aes_ready=1 -> AES_WAIT, msg_de captured into an internal MW-bit result buffer in the same edge.
REQ-012 AES_WAIT: to_sw_sig=2; to_hw_sig=0 -> SB, idx=0.
REQ-013 SB: to_sw_sig=1, to_sw_port = result buffer lane idx; to_hw_sig=2 -> SB_ACK.
REQ-014 SB_ACK: to_sw_sig=0, to_sw_port holds lane idx; on to_hw_sig=1:
- idx=MSG_BYTES-1 -> WAIT;
- otherwise idx+1 and -> SB.
REQ-015 to_sw_port=0 in every state except SB/SB_ACK; io_ready=1 only in AES_GO.
REQ-016 Timeout counter:
- cleared on every state change;
- increments each cycle spent in RD, RD_ACK, AES_GO, SB or SB_ACK, saturating;
- reaching TIMEOUT_CYC (when nonzero) -> ERR.
REQ-017 ERR: err=1, to_sw_sig=3, msg_en/key/result buffer hold their values; to_hw_sig=0 held for one cycle -> WAIT, err stays 1.
REQ-018 err clears only on reset or on WAIT seeing a new command (to_hw_sig=1, 2 or 3).
REQ-019 Result buffer only changes on the AES_GO capture edge; changes on msg_de at other times do not affect to_sw_port.
REQ-020 Parameter support: MSG_BYTES≠KEY_BYTES and MSG_BYTES, KEY_BYTES ≥ 1; single-lane transfers go RD_ACK -> WAIT after one byte.

Reset
REQ-021 reset_n=0 at a clock edge, from any state including mid-transfer, sets:
- state=RESET, idx=0, timeout counter=0;
- msg_en=0, key=0, result buffer=0, err=0.
REQ-022 During reset and in RESET: to_sw_sig=3, to_sw_port=0, io_ready=0; reset_n low with no clock edge has no effect.

Verification
REQ-023 Key load: 16 handshakes, lanes 0x00..0x0F -> key=128'h000102...0F, msg_en unchanged, returns to WAIT with to_sw_sig=0.
REQ-024 Full round trip: load message and key, sig=3, aes_ready pulse with msg_de=128'hDEADBEEF...; change msg_de after capture -> read-back lanes return DE,AD,BE,EF... from the captured value.
REQ-025 Timeout: TIMEOUT_CYC=8, stall in RD_ACK -> ERR after exactly 8 cycles, err=1, to_sw_sig=3; sig=0 -> WAIT with err=1; next sig=1 clears err.
REQ-026 Reset mid-transfer: reset_n low at message lane 7 -> next cycle msg_en=0, idx=0, to_sw_sig=3; one cycle later to_sw_sig=0.
REQ-027 Parameter sweep: PORT_W=16, MSG_BYTES=4, KEY_BYTES=2 -> 64-bit message and 32-bit key assembled MS-lane first; KEY_BYTES=1 completes after one handshake.

Source files
------------

// File: rtl/aes_io_bridge.sv
// Byte-lane handshake bridge between a narrow software port and an AES core:
// assembles message/key buses lane by lane and streams the AES result back out.
module aes_io_bridge #(
  parameter int PORT_W      = 8,
  parameter int MSG_BYTES   = 16,
  parameter int KEY_BYTES   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  to_hw_sig,
  input  logic [PORT_W-1:0]           to_hw_port,
  output logic [1:0]                  to_sw_sig,
  output logic [PORT_W-1:0]           to_sw_port,
  output logic [PORT_W*MSG_BYTES-1:0] msg_en,
  output logic [PORT_W*KEY_BYTES-1:0] key,
  input  logic [PORT_W*MSG_BYTES-1:0] msg_de,
  output logic                        io_ready,
  input  logic                        aes_ready,
  output logic                        err
);

  localparam int MW        = PORT_W * MSG_BYTES;
  localparam int KW        = PORT_W * KEY_BYTES;
  localparam int MAX_LANES = (MSG_BYTES > KEY_BYTES) ? MSG_BYTES : KEY_BYTES;
  localparam int IDX_W     = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;
  localparam int CNT_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [IDX_W-1:0] MSG_LAST = IDX_W'(MSG_BYTES - 1);
  localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_BYTES - 1);
  localparam logic             TGT_MSG  = 1'b0;
  localparam logic             TGT_KEY  = 1'b1;

  typedef enum logic [3:0] {
    S_RESET, S_WAIT, S_RD, S_RD_ACK, S_AES_GO, S_AES_WAIT, S_SB, S_SB_ACK, S_ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              target_reg, target_next;
  logic [CNT_W-1:0]  tmo_reg, tmo_next;
  logic              err_reg, err_next;
  logic              timed;
  logic              tmo_hit;
  logic [IDX_W-1:0]  rd_last;
  logic [MW-1:0]     msg_en_reg;
  logic [KW-1:0]     key_reg;
  logic [MW-1:0]     res_reg;
  logic [PORT_W-1:0] res_lane [MSG_BYTES];

  assign rd_last = (target_reg == TGT_KEY) ? KEY_LAST : MSG_LAST;
  assign tmo_hit = (TIMEOUT_CYC != 0) && (32'(tmo_reg) == TIMEOUT_CYC - 1);

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    target_next = target_reg;
    err_next    = err_reg;
    timed       = 1'b0;
    case (state_reg)
      S_RESET: state_next = S_WAIT;
      S_WAIT: begin
        case (to_hw_sig)
          2'd1: begin
            state_next  = S_RD;
            target_next = TGT_MSG;
            idx_next    = '0;
            err_next    = 1'b0;
          end
          2'd2: begin
            state_next  = S_RD;
            target_next = TGT_KEY;
            idx_next    = '0;
            err_next    = 1'b0;
          end
          2'd3: begin
            state_next = S_AES_GO;
            err_next   = 1'b0;
          end
          default: state_next = S_WAIT;
        endcase
      end
      S_RD: begin
        timed = 1'b1;
        if (to_hw_sig == 2'd2) state_next = S_RD_ACK;
      end
      S_RD_ACK: begin
        timed = 1'b1;
        if (to_hw_sig == 2'd1) begin
          if (idx_reg == rd_last) begin
            state_next = S_WAIT;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = S_RD;
          end
        end
      end
      S_AES_GO: begin
        timed = 1'b1;
        if (aes_ready) state_next = S_AES_WAIT;
      end
      S_AES_WAIT: begin
        if (to_hw_sig == 2'd0) begin
          state_next = S_SB;
          idx_next   = '0;
        end
      end
      S_SB: begin
        timed = 1'b1;
        if (to_hw_sig == 2'd2) state_next = S_SB_ACK;
      end
      S_SB_ACK: begin
        timed = 1'b1;
        if (to_hw_sig == 2'd1) begin
          if (idx_reg == MSG_LAST) begin
            state_next = S_WAIT;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = S_SB;
          end
        end
      end
      S_ERR: begin
        if (to_hw_sig == 2'd0) state_next = S_WAIT;
      end
      default: state_next = S_RESET;
    endcase

    // A completed handshake in the same cycle takes priority over the timeout.
    if (timed && tmo_hit && (state_next == state_reg)) begin
      state_next = S_ERR;
      err_next   = 1'b1;
    end

    tmo_next = tmo_reg;
    if (state_next != state_reg) begin
      tmo_next = '0;
    end else if (timed && (tmo_reg != {CNT_W{1'b1}})) begin
      tmo_next = tmo_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= S_RESET;
      idx_reg    <= '0;
      target_reg <= TGT_MSG;
      tmo_reg    <= '0;
      err_reg    <= 1'b0;
      msg_en_reg <= '0;
      key_reg    <= '0;
      res_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      target_reg <= target_next;
      tmo_reg    <= tmo_next;
      err_reg    <= err_next;
      // RD reloads the addressed lane every cycle until software acknowledges.
      if (state_reg == S_RD) begin
        for (int i = 0; i < MSG_BYTES; i++) begin
          if ((target_reg == TGT_MSG) && (idx_reg == IDX_W'(i)))
            msg_en_reg[MW-1-PORT_W*i -: PORT_W] <= to_hw_port;
        end
        for (int i = 0; i < KEY_BYTES; i++) begin
          if ((target_reg == TGT_KEY) && (idx_reg == IDX_W'(i)))
            key_reg[KW-1-PORT_W*i -: PORT_W] <= to_hw_port;
        end
      end
      if ((state_reg == S_AES_GO) && aes_ready) res_reg <= msg_de;
    end
  end

  for (genvar gi = 0; gi < MSG_BYTES; gi++) begin : g_res_lane
    assign res_lane[gi] = res_reg[MW-1-PORT_W*gi -: PORT_W];
  end

  always_comb begin
    to_sw_port = '0;
    if ((state_reg == S_SB) || (state_reg == S_SB_ACK)) begin
      for (int i = 0; i < MSG_BYTES; i++) begin
        if (idx_reg == IDX_W'(i)) to_sw_port = res_lane[i];
      end
    end
  end

  always_comb begin
    case (state_reg)
      S_RESET:    to_sw_sig = 2'd3;
      S_RD:       to_sw_sig = 2'd1;
      S_AES_WAIT: to_sw_sig = 2'd2;
      S_SB:       to_sw_sig = 2'd1;
      S_ERR:      to_sw_sig = 2'd3;
      default:    to_sw_sig = 2'd0;
    endcase
  end

  assign io_ready = (state_reg == S_AES_GO);
  assign err      = err_reg;
  assign msg_en   = msg_en_reg;
  assign key      = key_reg;

endmodule
